// File: rtl/ysyx_22040632_icache_refill_if.sv
// rtl/ysyx_22040632_icache_refill_if.sv - AXI-style read address / read data channel bundle for the I-cache refill
// Purpose: groups the AR and R channel signals between the refill controller (master) and memory (slave).
// Signals:
//   ar_valid/ar_ready/ar_addr/ar_len : read address channel
//   r_valid/r_ready/r_data/r_last    : read data channel
interface ysyx_22040632_icache_refill_if #(
    parameter int DATA_W = 64
);
    logic              ar_valid;
    logic              ar_ready;
    logic [31:0]       ar_addr;
    logic [7:0]        ar_len;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    modport master (
        output ar_valid, ar_addr, ar_len, r_ready,
        input  ar_ready, r_valid, r_data, r_last
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, r_ready,
        output ar_ready, r_valid, r_data, r_last
    );
endinterface

// File: rtl/ysyx_22040632_icache_refill.sv
// rtl/ysyx_22040632_icache_refill.sv - I-cache miss/refill controller, writer side of the 2-way tag array
// Purpose: on a lookup miss, picks a victim way, bursts the 64-byte line over the AR/R channels,
//          streams beats into the data array, installs the tag and pulses refill_done.
// Ports:
//   clk, rrst_n                         : clock, asynchronous active-low reset
//   req_valid, req_addr                 : IFU fetch request
//   hit_1st/hit_2nd, age_1st/age_2nd    : tag array lookup result and per-way age bits
//   fence_sig                           : fence.i
//   tag_wen_n, tag_w_way, tag_addr_*    : tag array write port (active-low enable)
//   axi (master)                        : read address / read data channels
//   data_wen, data_way/index/beat/wdata : data array beat write port
//   busy, refill_done, refill_err       : status
// Optional: define ICACHE_REFILL_PERF_EN to add perf_miss_cnt / perf_stall_cnt.
module ysyx_22040632_icache_refill #(
    parameter int TAG_W      = 21,
    parameter int INDEX_W    = 5,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 8
) (
    input  logic                clk,
    input  logic                rrst_n,
    input  logic                req_valid,
    input  logic [31:0]         req_addr,
    input  logic                hit_1st,
    input  logic                hit_2nd,
    input  logic                age_1st,
    input  logic                age_2nd,
    input  logic                fence_sig,
    output logic                tag_wen_n,
    output logic                tag_w_way,
    output logic [TAG_W-1:0]    tag_addr_tag,
    output logic [INDEX_W-1:0]  tag_addr_index,
    ysyx_22040632_icache_refill_if.master axi,
    output logic                data_wen,
    output logic                data_way,
    output logic [INDEX_W-1:0]  data_index,
    output logic [2:0]          data_beat,
    output logic [DATA_W-1:0]   data_wdata,
    output logic                busy,
    output logic                refill_done,
    output logic                refill_err
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]         perf_miss_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_TAGW = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic               way_q, way_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               fence_seen_q, fence_seen_d;
    // bad_q marks the current refill as unusable; err_q is the sticky status bit.
    logic               bad_q, bad_d;
    logic               ovr_q, ovr_d;
    logic               err_q, err_d;

    // Line offset bits and the second age bit play no role in the refill.
    logic unused_ok;
    assign unused_ok = ^{req_addr[5:0], age_2nd};

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            index_q      <= '0;
            way_q        <= 1'b0;
            cnt_q        <= '0;
            fence_seen_q <= 1'b0;
            bad_q        <= 1'b0;
            ovr_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            way_q        <= way_d;
            cnt_q        <= cnt_d;
            fence_seen_q <= fence_seen_d;
            bad_q        <= bad_d;
            ovr_q        <= ovr_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        index_d      = index_q;
        way_d        = way_q;
        cnt_d        = cnt_q;
        fence_seen_d = fence_seen_q;
        bad_d        = bad_q;
        ovr_d        = ovr_q;
        err_d        = err_q;
        axi.ar_valid = 1'b0;
        axi.r_ready  = 1'b0;
        data_wen     = 1'b0;
        tag_wen_n    = 1'b1;
        refill_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                fence_seen_d = 1'b0;
                bad_d        = 1'b0;
                ovr_d        = 1'b0;
                if (req_valid && !hit_1st && !hit_2nd && !fence_sig) begin
                    tag_d   = req_addr[31 -: TAG_W];
                    index_d = req_addr[6 +: INDEX_W];
                    // age bit set means most recently used, so evict the other way.
                    way_d   = age_1st;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                axi.ar_valid = 1'b1;
                if (fence_sig) fence_seen_d = 1'b1;
                if (axi.ar_ready) begin
                    cnt_d   = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                axi.r_ready = 1'b1;
                if (fence_sig) fence_seen_d = 1'b1;
                if (axi.r_valid) begin
                    // Beats past the line end are dropped but still drained.
                    data_wen = !ovr_q;
                    if (axi.r_last) begin
                        if (ovr_q || cnt_q != LAST_BEAT) begin
                            err_d = 1'b1;
                            bad_d = 1'b1;
                        end
                        state_d = S_TAGW;
                    end else if (cnt_q == LAST_BEAT) begin
                        ovr_d = 1'b1;
                        err_d = 1'b1;
                        bad_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_TAGW: begin
                // A fence in this very cycle clears the array, so it also vetoes the write.
                tag_wen_n = fence_seen_q | bad_q | fence_sig;
                state_d   = S_DONE;
            end
            S_DONE: begin
                refill_done = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign axi.ar_addr    = {tag_q, index_q, 6'b0};
    assign axi.ar_len     = axi.ar_valid ? 8'(LINE_BEATS - 1) : 8'd0;
    assign tag_w_way      = way_q;
    assign tag_addr_tag   = tag_q;
    assign tag_addr_index = index_q;
    assign data_way       = way_q;
    assign data_index     = index_q;
    assign data_beat      = cnt_q;
    assign data_wdata     = axi.r_data;
    assign busy           = (state_q != S_IDLE);
    assign refill_err     = err_q;

`ifdef ICACHE_REFILL_PERF_EN
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            perf_miss_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (state_q == S_IDLE && state_d == S_AR) perf_miss_cnt <= perf_miss_cnt + 32'd1;
            if (busy) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
